// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-store buffer: access sizes, drain FSM
// states, the FIFO entry layout and a few address helpers.
package sb_pkg;

  localparam int LANE_BYTES = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    size_e       size;
  } entry_t;

  // Natural alignment: the address is a multiple of the access size.
  function automatic logic is_aligned(input logic [63:0] addr, input size_e size);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr[0] == 1'b0);
      SZ_W:    ok = (addr[1:0] == 2'b00);
      default: ok = (addr[2:0] == 3'b000);
    endcase
    return ok;
  endfunction

  // Doubleword-aligned base address used on the memory port.
  function automatic logic [63:0] dw_addr(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core store/load handshake plus the shared data-memory port.
// slave = the store buffer, master = core and memory around it.
interface store_buffer_if;

  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        st_err;

  logic        ld_valid;
  logic [63:0] ld_addr;
  logic [63:0] ld_rdata;
  logic        ld_stall;

  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, mem_rdata,
    output st_ready, st_err, ld_rdata, ld_stall, mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, mem_rdata,
    input  st_ready, st_err, ld_rdata, ld_stall, mem_addr, mem_wdata, mem_write, mem_read
  );

endinterface

// File: rtl/store_buffer_lane_merge.sv
// Byte-lane merge for read-modify-write: lanes off..off+(1<<size)-1 take
// the right-justified store bytes, every other lane keeps the old dword.
module sb_lane_merge
  import sb_pkg::*;
#(
  parameter int NUM_LANES = LANE_BYTES
) (
  input  logic [NUM_LANES*8-1:0] old64,
  input  logic [NUM_LANES*8-1:0] data64,
  input  logic [2:0]             off3,
  input  logic [1:0]             size2,
  output logic [NUM_LANES*8-1:0] merged64
);

  logic [NUM_LANES-1:0][7:0] old_b;
  logic [NUM_LANES-1:0][7:0] data_b;
  logic [NUM_LANES-1:0][7:0] merged_b;
  logic [3:0]                lo;
  logic [3:0]                hi;

  assign old_b    = old64;
  assign data_b   = data64;
  assign merged64 = merged_b;

  // Aligned accesses never cross the dword, so hi never exceeds 8.
  assign lo = {1'b0, off3};
  assign hi = lo + (4'd1 << size2);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [2:0] src;
    logic       take;
    assign src         = 3'(l) - off3;
    assign take        = (4'(l) >= lo) && (4'(l) < hi);
    assign merged_b[l] = take ? data_b[src] : old_b[l];
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer: in-order FIFO of aligned stores drained to a
// 64-bit memory port, sharing that port with core loads (loads first).
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb,
  output logic          empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [63:0]   merge_q, merge_d;
  logic          st_err_q, st_err_d;

  entry_t           head;
  entry_t           st_entry;
  logic             full;
  logic             aligned;
  logic             enq;
  logic             pop;
  logic             overlap;
  logic             ld_grant;
  logic             own;
  logic [DEPTH-1:0] slot_hit;
  logic [63:0]      merged;

  assign head     = fifo_q[rd_ptr_q];
  assign full     = (count_q == FULL_CNT);
  assign aligned  = is_aligned(sb.st_addr, size_e'(sb.st_size));
  assign enq      = sb.st_valid && !full && aligned;
  assign st_entry = '{addr: sb.st_addr, data: sb.st_data, size: size_e'(sb.st_size)};

  // Flag occupied slots (head included, even mid-drain) in the load's dword.
  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_hit[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q) &&
                    (fifo_q[i].addr[63:3] == sb.ld_addr[63:3]);
    end
  end

  assign overlap  = |slot_hit;
  assign ld_grant = sb.ld_valid && !overlap;
  assign own      = !ld_grant;
  assign pop      = (state_q == WRITE) && own;

  sb_lane_merge #(
    .NUM_LANES(LANE_BYTES)
  ) u_merge (
    .old64   (sb.mem_rdata),
    .data64  (head.data),
    .off3    (head.addr[2:0]),
    .size2   (head.size),
    .merged64(merged)
  );

  // FIFO bookkeeping and drain sequencing; a granted load freezes the FSM.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    merge_d  = merge_q;
    st_err_d = sb.st_valid && !full && !aligned;

    if (enq) begin
      fifo_d[wr_ptr_q] = st_entry;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    if (own) begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_d = (head.size == SZ_D) ? WRITE : READ;
          end
        end
        READ: begin
          merge_d = merged;
          state_d = WRITE;
        end
        WRITE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      merge_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      merge_q  <= merge_d;
      st_err_q <= st_err_d;
    end
  end

  // Memory port mux: a granted load wins, otherwise the drain FSM drives it.
  always_comb begin
    sb.mem_addr  = '0;
    sb.mem_wdata = '0;
    sb.mem_write = 1'b0;
    sb.mem_read  = 1'b0;
    sb.ld_rdata  = '0;
    sb.ld_stall  = 1'b0;
    if (!reset) begin
      if (ld_grant) begin
        sb.mem_addr = sb.ld_addr;
        sb.mem_read = 1'b1;
        sb.ld_rdata = sb.mem_rdata;
      end else begin
        sb.ld_stall = sb.ld_valid;
        case (state_q)
          READ: begin
            sb.mem_addr = dw_addr(head.addr);
            sb.mem_read = 1'b1;
          end
          WRITE: begin
            sb.mem_addr  = dw_addr(head.addr);
            sb.mem_wdata = (head.size == SZ_D) ? head.data : merge_q;
            sb.mem_write = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign sb.st_ready = reset || !full;
  assign sb.st_err   = st_err_q;
  assign empty       = reset || ((count_q == '0) && (state_q == IDLE));

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed timing steps followed by random
// stores/loads checked against a byte-array model of memory.
module tb_store_buffer;

  logic clk = 1'b0;
  logic reset;
  logic empty;

  always #5 clk = ~clk;

  store_buffer_if sbif ();

  store_buffer #(.DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sbif),
    .empty(empty)
  );

  // Environment memory: 64 dwords covering byte addresses 0x000..0x1FF.
  logic [63:0] mem [64];
  logic        mem_clr;
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [63:0] pre_val;
  int          wcnt;

  assign sbif.mem_rdata = mem[sbif.mem_addr[8:3]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (sbif.mem_write) begin
      mem[sbif.mem_addr[8:3]] <= sbif.mem_wdata;
      wcnt <= wcnt + 1;
    end
  end

  // Reference model: plain byte array, updated when a store is accepted.
  logic [7:0] ref_b [512];
  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
    for (int b = 0; b < (1 << sz); b++) ref_b[int'(a[8:0]) + b] = d[8*b +: 8];
  endtask

  function automatic logic [63:0] ref_dw(input logic [63:0] a);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = ref_b[int'({a[8:3], 3'b000}) + b];
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic preload(input logic [5:0] idx, input logic [63:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    ref_store({55'd0, idx, 3'b000}, val, 2'b11);
    step();
    pre_we = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int t = 0;
    #1;
    while (!empty && t < 50) begin step(); #1; t++; end
    chk(tag, empty, 1'b1);
    step();
  endtask

  // Present a store until accepted, then check the error pulse.
  task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
    int  t = 0;
    logic al;
    al = ((a % (64'd1 << sz)) == 0);
    sbif.st_addr  = a;
    sbif.st_data  = d;
    sbif.st_size  = sz;
    sbif.st_valid = 1'b1;
    #1;
    while (!sbif.st_ready && t < 30) begin step(); #1; t++; end
    chk("st_ready_wait", sbif.st_ready, 1'b1);
    step();
    sbif.st_valid = 1'b0;
    if (al) ref_store(a, d, sz);
    #1;
    chk("st_err", sbif.st_err, !al);
    step();
  endtask

  // Issue a load, ride out any stall, compare against the model.
  task automatic do_load(input logic [63:0] a);
    int t = 0;
    sbif.ld_addr  = a;
    sbif.ld_valid = 1'b1;
    #1;
    while (sbif.ld_stall && t < 30) begin step(); #1; t++; end
    chk("ld_unstall", sbif.ld_stall, 1'b0);
    chk("ld_rdata", sbif.ld_rdata, ref_dw(a));
    sbif.ld_valid = 1'b0;
    step();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] a, d;
    logic [1:0]  sz;
    int          w0, ns, t;
    logic        st_pend, accept;

    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 512; i++) ref_b[i] = '0;
    reset = 1'b1; mem_clr = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    sbif.st_valid = 1'b0; sbif.st_addr = '0; sbif.st_data = '0; sbif.st_size = '0;
    sbif.ld_valid = 1'b0; sbif.ld_addr = '0;

    // Reset values
    step(); step(); #1;
    chk("rst_st_ready", sbif.st_ready, 1'b1);
    chk("rst_st_err", sbif.st_err, 1'b0);
    chk("rst_ld_stall", sbif.ld_stall, 1'b0);
    chk("rst_mem_write", sbif.mem_write, 1'b0);
    chk("rst_mem_read", sbif.mem_read, 1'b0);
    chk("rst_mem_addr", sbif.mem_addr, 64'd0);
    chk("rst_mem_wdata", sbif.mem_wdata, 64'd0);
    chk("rst_ld_rdata", sbif.ld_rdata, 64'd0);
    chk("rst_empty", empty, 1'b1);
    reset = 1'b0; mem_clr = 1'b0;
    step(); #1;
    chk("post_rst_empty", empty, 1'b1);
    chk("post_rst_ready", sbif.st_ready, 1'b1);
    step();

    // Doubleword store: written at E2, then loaded back without stall
    sbif.st_addr = 64'h10; sbif.st_data = 64'h1122334455667788; sbif.st_size = 2'b11;
    sbif.st_valid = 1'b1;
    ref_store(64'h10, 64'h1122334455667788, 2'b11);
    step(); sbif.st_valid = 1'b0; #1;
    chk("dw_e0_nowrite", sbif.mem_write, 1'b0);
    chk("dw_e0_not_empty", empty, 1'b0);
    step(); #1;
    chk("dw_e1_write", sbif.mem_write, 1'b1);
    chk("dw_e1_addr", sbif.mem_addr, 64'h10);
    chk("dw_e1_wdata", sbif.mem_wdata, 64'h1122334455667788);
    chk("dw_e1_mem_old", mem[2], 64'd0);
    step(); #1;
    chk("dw_e2_mem", mem[2], 64'h1122334455667788);
    chk("dw_e2_empty", empty, 1'b1);
    sbif.ld_addr = 64'h10; sbif.ld_valid = 1'b1; #1;
    chk("dw_ld_stall", sbif.ld_stall, 1'b0);
    chk("dw_ld_read", sbif.mem_read, 1'b1);
    chk("dw_ld_rdata", sbif.ld_rdata, 64'h1122334455667788);
    sbif.ld_valid = 1'b0;
    step();

    // Byte store: READ at E1, WRITE at E2, memory updated at E3
    preload(6'd1, 64'h02);
    sbif.st_addr = 64'h09; sbif.st_data = 64'hAB; sbif.st_size = 2'b00;
    sbif.st_valid = 1'b1;
    ref_store(64'h09, 64'hAB, 2'b00);
    step(); sbif.st_valid = 1'b0; #1;
    chk("b_e0_noread", sbif.mem_read, 1'b0);
    step(); #1;
    chk("b_e1_read", sbif.mem_read, 1'b1);
    chk("b_e1_addr", sbif.mem_addr, 64'h08);
    chk("b_e1_nowrite", sbif.mem_write, 1'b0);
    step(); #1;
    chk("b_e2_write", sbif.mem_write, 1'b1);
    chk("b_e2_wdata", sbif.mem_wdata, 64'hAB02);
    step(); #1;
    chk("b_e3_mem", mem[1], 64'h000000000000AB02);
    chk("b_e3_empty", empty, 1'b1);
    step();

    // Fill while a non-overlapping load hogs the port, then drain in order
    sbif.ld_addr = 64'h38; sbif.ld_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a = 64'h40 + 64'(8 * k);
      d = 64'h0101010101010101 * 64'(k + 1);
      sbif.st_addr = a; sbif.st_data = d; sbif.st_size = 2'b11; sbif.st_valid = 1'b1;
      ref_store(a, d, 2'b11);
      exp_q.push_back(a);
      #1;
      chk("fill_ready", sbif.st_ready, (k < 4));
      chk("fill_ld_read", sbif.mem_read, 1'b1);
      step();
    end
    sbif.ld_valid = 1'b0;
    #1;
    chk("fill_full", sbif.st_ready, 1'b0);
    st_pend = 1'b1;
    t = 0;
    while (exp_q.size() > 0 && t < 60) begin
      if (sbif.mem_write) begin
        if (exp_q.size() == 5) chk("full_pop_reject", sbif.st_ready, 1'b0);
        chk("fill_order", sbif.mem_addr, exp_q.pop_front());
      end
      accept = st_pend && sbif.st_ready;
      step();
      if (accept) begin sbif.st_valid = 1'b0; st_pend = 1'b0; end
      #1;
      t++;
    end
    chk("fill_drained", 64'(exp_q.size()), 64'd0);
    wait_empty("fill_empty");
    #1;
    chk("fill_ready_back", sbif.st_ready, 1'b1);
    step();

    // Misaligned half store: error pulse, nothing queued or written
    w0 = wcnt;
    sbif.st_addr = 64'h03; sbif.st_data = 64'hFFFF; sbif.st_size = 2'b01; sbif.st_valid = 1'b1;
    step(); sbif.st_valid = 1'b0; #1;
    chk("mis_err", sbif.st_err, 1'b1);
    chk("mis_empty", empty, 1'b1);
    step(); #1;
    chk("mis_err_clear", sbif.st_err, 1'b0);
    chk("mis_no_write", 64'(wcnt), 64'(w0));
    chk("mis_mem", mem[0], 64'd0);
    step();

    // Overlapping load stalls until the word store pops
    preload(6'd4, 64'h0123456789ABCDEF);
    sbif.st_addr = 64'h20; sbif.st_data = 64'h55AA55AADEADBEEF; sbif.st_size = 2'b10;
    sbif.st_valid = 1'b1;
    ref_store(64'h20, 64'h55AA55AADEADBEEF, 2'b10);
    step(); sbif.st_valid = 1'b0;
    sbif.ld_addr = 64'h24; sbif.ld_valid = 1'b1; #1;
    chk("ovl_stall", sbif.ld_stall, 1'b1);
    ns = 0;
    while (sbif.ld_stall && ns < 20) begin ns++; step(); #1; end
    chk("ovl_stall_cycles", 64'(ns), 64'd3);
    chk("ovl_rdata", sbif.ld_rdata, 64'h01234567DEADBEEF);
    chk("ovl_rdata_model", sbif.ld_rdata, ref_dw(64'h20));
    sbif.ld_valid = 1'b0;
    step();

    // Reset while in WRITE: no write, entry discarded
    w0 = wcnt;
    sbif.st_addr = 64'h98; sbif.st_data = 64'hCAFEF00DCAFEF00D; sbif.st_size = 2'b11;
    sbif.st_valid = 1'b1;
    step(); sbif.st_valid = 1'b0;
    step(); #1;
    chk("rw_in_write", sbif.mem_write, 1'b1);
    reset = 1'b1; #1;
    chk("rw_write_gated", sbif.mem_write, 1'b0);
    step(); reset = 1'b0; #1;
    chk("rw_empty", empty, 1'b1);
    chk("rw_ready", sbif.st_ready, 1'b1);
    chk("rw_mem", mem[19], 64'd0);
    step(); step(); step(); #1;
    chk("rw_no_write", 64'(wcnt), 64'(w0));
    chk("rw_still_empty", empty, 1'b1);
    step();

    // Random mix of stores (some misaligned) and loads
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load(64'h100 + 64'(8 * $urandom_range(0, 31)));
      end else begin
        sz = 2'($urandom_range(0, 3));
        a  = 64'h100 + 64'($urandom_range(0, 255));
        if ($urandom_range(0, 4) != 0) a = a & ~((64'd1 << sz) - 64'd1);
        d  = {$urandom, $urandom};
        do_store(a, d, sz);
      end
    end
    wait_empty("rand_empty");
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_dw(64'(i * 8)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
